// File: rtl/afifo_rd_drain.sv
// afifo_rd_drain: read-domain drain stage behind the async FIFO's FWFT read port.
// It pops FIFO words into a 2-entry skid buffer and presents them on a valid/ready stream.
// It also counts the completed output handshakes.
module afifo_rd_drain #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned CNTW  = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             out_valid,
  output logic [DSIZE-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occ,
  output logic [CNTW-1:0]  xfer_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] tail_q, tail_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             push;
  logic             pop;

  // The pop strobe depends only on registered occupancy, so downstream ready never reaches the FIFO
  assign rinc      = !rrst && !rempty && (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_q;
  assign occ       = 2'(state_q);
  assign xfer_cnt  = cnt_q;
  assign push      = rinc;
  assign pop       = out_valid && out_ready;

  // State, slots and counter registers; an asynchronous reset discards any buffered words
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: the head always holds the oldest word, and the tail is used only when both slots are full
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = pop ? cnt_q + CNTW'(1) : cnt_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = rdata;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = rdata;
        end else if (push) begin
          tail_d  = rdata;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_afifo_rd_drain.sv
// Bench for afifo_rd_drain: a queue-modelled FIFO source feeds a scoreboard, and a negedge monitor checks the outputs.
module tb_afifo_rd_drain;

  logic        rclk = 1'b0;
  logic        rrst;
  logic        rempty;
  logic [7:0]  rdata;
  logic        out_ready;

  logic        rinc, out_valid;
  logic [7:0]  out_data;
  logic [1:0]  occ;
  logic [15:0] xfer_cnt;

  logic        rinc4, out_valid4;
  logic [7:0]  out_data4;
  logic [1:0]  occ4;
  logic [3:0]  xfer_cnt4;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  src[$];
  logic [7:0]  exp_q[$];
  int unsigned hs_cnt = 0;
  bit          force_empty = 1'b0;

  afifo_rd_drain #(.DSIZE(8), .CNTW(16)) dut (
    .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occ(occ), .xfer_cnt(xfer_cnt)
  );

  afifo_rd_drain #(.DSIZE(8), .CNTW(4)) dut4 (
    .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc4),
    .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready),
    .occ(occ4), .xfer_cnt(xfer_cnt4)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // FIFO model: first-word-fall-through with the head word on rdata
  task automatic apply_inputs();
    rempty = force_empty || (src.size() == 0);
    rdata  = (src.size() != 0) ? src[0] : 8'h00;
  endtask

  // One clock: see whether a pop is requested, let the edge occur, then record the popped word as expected output
  task automatic cycle();
    bit took;
    @(negedge rclk);
    took = rinc;
    @(posedge rclk);
    #1;
    if (took) exp_q.push_back(src.pop_front());
    apply_inputs();
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    src.delete();
    force_empty = 1'b0;
    out_ready = 1'b0;
    apply_inputs();
    #1;
    chk("rst_occ", 32'(occ), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_rinc", 32'(rinc), 0);
    chk("rst_cnt", 32'(xfer_cnt), 0);
    cycle();
    cycle();
    rrst = 1'b0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    out_ready = 1'b1;
    force_empty = 1'b0;
    apply_inputs();
    while ((src.size() != 0 || exp_q.size() != 0) && n < max) begin
      cycle();
      n++;
    end
    chk("drain_done", 32'(src.size() + exp_q.size()), 0);
  endtask

  // Monitor: compare the outputs with the occupancy and order derived from the scoreboard, then retire handshakes
  always @(negedge rclk) begin
    if (rrst) begin
      chk("in_rst_rinc", 32'(rinc), 0);
      chk("in_rst_valid", 32'(out_valid), 0);
      chk("in_rst_occ", 32'(occ), 0);
      chk("in_rst_cnt", 32'(xfer_cnt), 0);
      chk("in_rst_data", 32'(out_data), 0);
      exp_q.delete();
      hs_cnt = 0;
    end else begin
      chk("occ", 32'(occ), 32'(exp_q.size()));
      chk("occ4", 32'(occ4), 32'(exp_q.size()));
      chk("valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("rinc", 32'(rinc), 32'(!rempty && exp_q.size() != 2));
      chk("rinc4", 32'(rinc4), 32'(!rempty && exp_q.size() != 2));
      chk("xfer_cnt", 32'(xfer_cnt), 32'(hs_cnt % 65536));
      chk("xfer_cnt4", 32'(xfer_cnt4), 32'(hs_cnt % 16));
      if (out_valid && exp_q.size() != 0) begin
        chk("out_data", 32'(out_data), 32'(exp_q[0]));
        chk("out_data4", 32'(out_data4), 32'(exp_q[0]));
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        hs_cnt++;
      end
    end
  end

  initial begin
    // Reset with a word already waiting in the FIFO
    rrst = 1'b1;
    out_ready = 1'b0;
    src.push_back(8'hA5);
    apply_inputs();
    #1;
    chk("init_rinc", 32'(rinc), 0);
    chk("init_valid", 32'(out_valid), 0);
    chk("init_data", 32'(out_data), 0);
    chk("init_occ", 32'(occ), 0);
    repeat (3) cycle();
    rrst = 1'b0;
    #1;
    chk("release_rinc", 32'(rinc), 1);
    cycle();
    chk("first_valid", 32'(out_valid), 1);
    chk("first_data", 32'(out_data), 32'h A5);
    drain(10);

    // Streaming at one word per cycle
    do_reset();
    for (int i = 0; i < 16; i++) src.push_back(8'(i));
    out_ready = 1'b1;
    apply_inputs();
    repeat (17) cycle();
    chk("stream_cnt", 32'(xfer_cnt), 16);
    chk("stream_occ", 32'(occ), 0);
    chk("stream_left", 32'(src.size() + exp_q.size()), 0);

    // Backpressure with five words available
    do_reset();
    for (int i = 0; i < 5; i++) src.push_back(8'(8'h30 + i));
    out_ready = 1'b0;
    apply_inputs();
    repeat (6) cycle();
    chk("bp_pops", 32'(src.size()), 3);
    chk("bp_occ", 32'(occ), 2);
    chk("bp_rinc", 32'(rinc), 0);
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_data", 32'(out_data), 32'h30);
    drain(20);
    chk("bp_cnt", 32'(xfer_cnt), 5);

    // Empty flag toggling each cycle with random backpressure
    do_reset();
    for (int i = 0; i < 40; i++) src.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 100; i++) begin
      force_empty = (i % 2) == 1;
      out_ready = 1'($urandom_range(0, 1));
      apply_inputs();
      cycle();
    end
    drain(60);

    // Counter wrap on the narrow-counter instance
    do_reset();
    for (int i = 0; i < 17; i++) src.push_back(8'($urandom_range(0, 255)));
    out_ready = 1'b1;
    apply_inputs();
    repeat (18) cycle();
    chk("wrap_cnt4", 32'(xfer_cnt4), 1);
    chk("wrap_cnt16", 32'(xfer_cnt), 17);

    // Asynchronous reset while both slots are full
    do_reset();
    for (int i = 0; i < 6; i++) src.push_back(8'(8'h50 + i));
    out_ready = 1'b1;
    apply_inputs();
    repeat (3) cycle();
    out_ready = 1'b0;
    apply_inputs();
    repeat (3) cycle();
    chk("mid_occ_before", 32'(occ), 2);
    chk("mid_cnt_before", 32'(xfer_cnt), 2);
    rrst = 1'b1;
    #1;
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_rinc", 32'(rinc), 0);
    chk("mid_occ", 32'(occ), 0);
    chk("mid_cnt", 32'(xfer_cnt), 0);
    src.delete();
    apply_inputs();
    cycle();
    rrst = 1'b0;
    for (int i = 0; i < 3; i++) src.push_back(8'(8'h70 + i));
    drain(10);
    chk("post_rst_cnt", 32'(xfer_cnt), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
